lander_thrust_ctrl: RTL and testbench

Thrust-lever controller between the player input layer and the game core's 8-bit THRUST input. It arbitrates between the analog stick and a digital ramp driven by d-pad or keys, with optional automatic hand-over between the two sources. It runs a prescaled ramp accumulator and clamps the value to the lever DAC's legal range of 0–MAX_THRUST. Hand-over from analog to digital is bumpless. It runs in the video/input clock domain, beside the input decode logic.

---
 rtl/lander_thrust_ctrl.sv | 146 ++++++++++++++
 tb/tb_lander_thrust_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lander_thrust_ctrl.sv
// Thrust-lever controller: arbitrates analog stick vs. digital ramp and
// drives a clamped, registered 8-bit thrust value with bumpless hand-over.
module lander_thrust_ctrl #(
    parameter int unsigned TICK_DIV   = 98425,
    parameter int unsigned MAX_THRUST = 254,
    parameter int unsigned DEADZONE   = 8
) (
    input  logic              clk_25,
    input  logic              reset,
    input  logic [1:0]        mode,
    input  logic signed [7:0] analog_y,
    input  logic              thr_inc,
    input  logic              thr_dec,
    output logic [7:0]        thrust,
    output logic              src_dig
);

    localparam int unsigned PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [7:0]  MAX_T    = 8'(MAX_THRUST);
    localparam logic [8:0]  DZ       = 9'(DEADZONE);

    typedef enum logic {
        S_ANA,
        S_DIG
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [7:0]    acc;
    logic [7:0]    ref_y;
    logic [PW-1:0] presc;
    logic          inc_d;
    logic          dec_d;

    logic [8:0]    a_full;
    logic [7:0]    a_thr;
    logic [8:0]    diff;
    logic [8:0]    diff_mag;
    logic          far;
    logic          any_btn;
    logic          one_held;
    logic          rise;
    logic          pre_term;
    logic          step;
    logic          apply_step;
    logic          load;
    logic [7:0]    acc_stepped;

    // Stick is inverted: full forward (-128) gives the largest thrust.
    assign a_full = 9'd127 - {analog_y[7], analog_y};
    assign a_thr  = (a_full > {1'b0, MAX_T}) ? MAX_T : a_full[7:0];

    assign diff     = {analog_y[7], analog_y} - {ref_y[7], ref_y};
    assign diff_mag = diff[8] ? (9'd0 - diff) : diff;
    assign far      = (diff_mag > DZ);

    assign any_btn  = thr_inc | thr_dec;
    assign one_held = thr_inc ^ thr_dec;
    assign rise     = one_held & ((thr_inc & ~inc_d) | (thr_dec & ~dec_d));
    assign pre_term = one_held & ~rise & (presc == PRE_LAST);
    assign step     = rise | pre_term;

    always_comb begin
        acc_stepped = acc;
        if (thr_inc) begin
            if (acc < MAX_T) begin
                acc_stepped = acc + 8'd1;
            end
        end else begin
            if (acc != 8'd0) begin
                acc_stepped = acc - 8'd1;
            end
        end
    end

    // Buttons win over stick movement while the digital source owns the lever.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (mode)
            2'd0: state_next = S_ANA;
            2'd1: state_next = S_DIG;
            default: begin
                if (state == S_ANA) begin
                    if (any_btn) begin
                        state_next = S_DIG;
                        load       = 1'b1;
                    end
                end else if (!any_btn && far) begin
                    state_next = S_ANA;
                end
            end
        endcase
    end

    assign apply_step = step & ((state == S_DIG) | (state_next == S_DIG));

    always_ff @(posedge clk_25 or posedge reset) begin
        if (reset) begin
            state <= S_ANA;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk_25 or posedge reset) begin
        if (reset) begin
            inc_d <= 1'b0;
            dec_d <= 1'b0;
            presc <= '0;
        end else begin
            inc_d <= thr_inc;
            dec_d <= thr_dec;
            if (!one_held || rise || pre_term) begin
                presc <= '0;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

    // The hand-over load captures the current analog value so the switch is bumpless.
    always_ff @(posedge clk_25 or posedge reset) begin
        if (reset) begin
            acc   <= 8'd0;
            ref_y <= 8'd0;
        end else if (load) begin
            acc   <= a_thr;
            ref_y <= analog_y;
        end else if (apply_step) begin
            acc   <= acc_stepped;
        end
    end

    always_ff @(posedge clk_25 or posedge reset) begin
        if (reset) begin
            thrust <= 8'd0;
        end else begin
            thrust <= (state == S_DIG) ? acc : a_thr;
        end
    end

    assign src_dig = (state == S_DIG);

endmodule

// File: tb/tb_lander_thrust_ctrl.sv
// Randomized and directed bench for lander_thrust_ctrl, checked every cycle
// against a behavioural model of the thrust-lever rules.
module tb_lander_thrust_ctrl;

    localparam int TICK = 4;

    logic              clk_25;
    logic              reset;
    logic [1:0]        mode;
    logic signed [7:0] analog_y;
    logic              thr_inc;
    logic              thr_dec;
    logic [7:0]        thrust;
    logic              src_dig;

    int tests;
    int fails;
    bit started;

    lander_thrust_ctrl #(
        .TICK_DIV  (TICK),
        .MAX_THRUST(254),
        .DEADZONE  (8)
    ) dut (
        .clk_25  (clk_25),
        .reset   (reset),
        .mode    (mode),
        .analog_y(analog_y),
        .thr_inc (thr_inc),
        .thr_dec (thr_dec),
        .thrust  (thrust),
        .src_dig (src_dig)
    );

    initial clk_25 = 1'b0;
    always #5 clk_25 = ~clk_25;

    // Behavioural model state, kept as plain integers.
    int m_acc;
    int m_ref;
    int m_hold;
    int m_thrust;
    bit m_dig;
    bit m_pinc;
    bit m_pdec;
    int y;
    int a;
    bit inc_now;
    bit dec_now;
    bit rise_now;
    bit step_now;
    bit dig_next;

    function automatic int analog_thrust(input int yy);
        int v;
        v = 127 - yy;
        return (v > 254) ? 254 : v;
    endfunction

    function automatic int abs_int(input int v);
        return (v < 0) ? -v : v;
    endfunction

    always @(posedge clk_25 or posedge reset) begin
        if (reset) begin
            m_acc    = 0;
            m_ref    = 0;
            m_hold   = 0;
            m_thrust = 0;
            m_dig    = 1'b0;
            m_pinc   = 1'b0;
            m_pdec   = 1'b0;
        end else begin
            y        = analog_y;
            a        = analog_thrust(y);
            inc_now  = thr_inc;
            dec_now  = thr_dec;
            rise_now = (inc_now != dec_now) && ((inc_now && !m_pinc) || (dec_now && !m_pdec));
            step_now = 1'b0;
            if (rise_now) begin
                step_now = 1'b1;
                m_hold   = 0;
            end else if (inc_now != dec_now) begin
                m_hold = m_hold + 1;
                if (m_hold == TICK) begin
                    step_now = 1'b1;
                    m_hold   = 0;
                end
            end else begin
                m_hold = 0;
            end

            if (mode == 2'd0) begin
                dig_next = 1'b0;
            end else if (mode == 2'd1) begin
                dig_next = 1'b1;
            end else if (!m_dig) begin
                dig_next = inc_now || dec_now;
            end else if (inc_now || dec_now) begin
                dig_next = 1'b1;
            end else begin
                dig_next = !(abs_int(y - m_ref) > 8);
            end

            m_thrust = m_dig ? m_acc : a;

            if (mode[1] && !m_dig && (inc_now || dec_now)) begin
                m_acc = a;
                m_ref = y;
            end else if (step_now && (m_dig || dig_next)) begin
                if (inc_now) m_acc = (m_acc + 1 > 254) ? 254 : m_acc + 1;
                else         m_acc = (m_acc - 1 < 0) ? 0 : m_acc - 1;
            end

            m_dig  = dig_next;
            m_pinc = inc_now;
            m_pdec = dec_now;
        end
    end

    always @(negedge clk_25) begin
        if (started && !reset) begin
            tests = tests + 1;
            if (thrust !== 8'(m_thrust)) begin
                fails = fails + 1;
                $display("[TB] FAIL model_thrust at %0t: got %0d expected %0d", $time, thrust, m_thrust);
            end
            tests = tests + 1;
            if (src_dig !== m_dig) begin
                fails = fails + 1;
                $display("[TB] FAIL model_src_dig at %0t: got %0d expected %0d", $time, src_dig, m_dig);
            end
        end
    end

    task automatic applyStimulus(input logic [1:0] m, input int yy, input logic i, input logic d, input int n);
        mode     = m;
        analog_y = 8'(yy);
        thr_inc  = i;
        thr_dec  = d;
        repeat (n) @(negedge clk_25);
    endtask

    task automatic checkOutput(input string name, input int exp_thrust, input logic exp_src);
        tests = tests + 1;
        if (thrust !== 8'(exp_thrust) || src_dig !== exp_src) begin
            fails = fails + 1;
            $display("[TB] FAIL %s: thrust=%0d src_dig=%0d, expected thrust=%0d src_dig=%0d",
                     name, thrust, src_dig, exp_thrust, exp_src);
        end
    endtask

    task automatic doReset();
        thr_inc = 1'b0;
        thr_dec = 1'b0;
        reset   = 1'b1;
        repeat (2) @(negedge clk_25);
        reset   = 1'b0;
    endtask

    int j;

    initial begin
        tests    = 0;
        fails    = 0;
        started  = 1'b0;
        reset    = 1'b1;
        mode     = 2'd0;
        analog_y = 8'sd0;
        thr_inc  = 1'b0;
        thr_dec  = 1'b0;
        repeat (3) @(negedge clk_25);
        checkOutput("reset_state", 0, 1'b0);
        reset   = 1'b0;
        started = 1'b1;

        applyStimulus(2'd0, -128, 1'b0, 1'b0, 1);
        checkOutput("analog_fwd", 254, 1'b0);
        applyStimulus(2'd0, 0, 1'b0, 1'b0, 1);
        checkOutput("analog_mid", 127, 1'b0);
        applyStimulus(2'd0, 127, 1'b0, 1'b0, 1);
        checkOutput("analog_back", 0, 1'b0);

        doReset();
        applyStimulus(2'd1, 0, 1'b1, 1'b0, 2);
        checkOutput("ramp_edge_step", 1, 1'b1);
        applyStimulus(2'd1, 0, 1'b1, 1'b0, 4);
        checkOutput("ramp_first_tick", 2, 1'b1);
        applyStimulus(2'd1, 0, 1'b1, 1'b0, 1194);
        checkOutput("ramp_saturate", 254, 1'b1);
        applyStimulus(2'd1, 0, 1'b0, 1'b1, 1200);
        checkOutput("ramp_floor", 0, 1'b1);
        applyStimulus(2'd1, 0, 1'b0, 1'b0, 1);
        for (int k = 0; k < 50; k++) begin
            applyStimulus(2'd1, 0, 1'b1, 1'b0, 1);
            applyStimulus(2'd1, 0, 1'b0, 1'b0, 1);
        end
        checkOutput("pulse_to_50", 50, 1'b1);
        applyStimulus(2'd1, 0, 1'b1, 1'b1, 100);
        checkOutput("both_buttons", 50, 1'b1);
        applyStimulus(2'd1, 0, 1'b0, 1'b0, 1);

        doReset();
        applyStimulus(2'd2, -40, 1'b0, 1'b0, 2);
        checkOutput("auto_analog", 167, 1'b0);
        applyStimulus(2'd2, -40, 1'b1, 1'b0, 1);
        checkOutput("handover_cycle", 167, 1'b1);
        applyStimulus(2'd2, -40, 1'b0, 1'b0, 1);
        checkOutput("handover_bumpless", 167, 1'b1);
        applyStimulus(2'd2, -40, 1'b1, 1'b0, 1);
        applyStimulus(2'd2, -40, 1'b0, 1'b0, 1);
        checkOutput("second_pulse", 168, 1'b1);
        applyStimulus(2'd2, -48, 1'b0, 1'b0, 3);
        checkOutput("deadzone_edge", 168, 1'b1);
        applyStimulus(2'd2, -49, 1'b0, 1'b0, 1);
        checkOutput("reclaim_state", 168, 1'b0);
        applyStimulus(2'd2, -49, 1'b0, 1'b0, 1);
        checkOutput("reclaim_value", 176, 1'b0);
        applyStimulus(2'd1, -49, 1'b0, 1'b0, 2);
        checkOutput("retained_acc", 168, 1'b1);

        doReset();
        applyStimulus(2'd2, 37, 1'b1, 1'b0, 1);
        applyStimulus(2'd2, 37, 1'b0, 1'b0, 1);
        applyStimulus(2'd1, 37, 1'b0, 1'b0, 1);
        checkOutput("acc_90", 90, 1'b1);
        thr_inc = 1'b1;
        #2 reset = 1'b1;
        #1 checkOutput("async_reset", 0, 1'b0);
        #1 reset = 1'b0;
        repeat (2) @(negedge clk_25);
        checkOutput("held_through_reset", 1, 1'b1);

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 63) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) begin
                analog_y = 8'($urandom);
            end else if ($urandom_range(0, 3) == 0) begin
                j = int'(analog_y) + int'($urandom_range(0, 20)) - 10;
                if (j > 127) j = 127;
                if (j < -128) j = -128;
                analog_y = 8'(j);
            end
            if ($urandom_range(0, 7) == 0) thr_inc = ~thr_inc;
            if ($urandom_range(0, 7) == 0) thr_dec = ~thr_dec;
            if ($urandom_range(0, 999) == 0) begin
                #2 reset = 1'b1;
                #2 reset = 1'b0;
            end
            @(negedge clk_25);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
